// File: rtl/rx_frame_checker.sv
// UART receive frame checker: start/data/parity/stop tracking per bit strobe.
// Optional error counter enabled by defining RX_ERR_COUNT_EN.
module rx_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  input  logic                  parity_en,
  input  logic                  parity_odd,
`ifdef RX_ERR_COUNT_EN
  input  logic                  err_clr,
  output logic [ERR_CNT_W-1:0]  err_count,
`endif
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  frame_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  localparam logic [3:0] LAST_D = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par;
  logic                  r_pen;
  logic                  r_podd;
  logic                  r_perr;
  logic                  r_ferr;

  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_fv;
  logic                  r_perr_o;
  logic                  r_ferr_o;
  logic                  r_busy;

  logic                  w_start;
  logic                  w_data_last;
  logic                  w_done;
  logic                  w_ferr_fin;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-strobe control decode
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_data_last = 1'b0;
    w_done      = 1'b0;
    w_ferr_fin  = r_ferr | ~bit_in;
    if (bit_valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (!bit_in) begin
            w_start     = 1'b1;
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          if (r_cnt == LAST_D) begin
            w_data_last = 1'b1;
            w_state_nxt = r_pen ? S_PAR : S_STOP;
          end
        end
        S_PAR: begin
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          if (r_cnt == LAST_S) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Frame datapath: shift, counter, running parity and sticky errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_pen   <= 1'b0;
      r_podd  <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else if (w_start) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_pen   <= parity_en;
      r_podd  <= parity_odd;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else if (bit_valid) begin
      unique case (r_state)
        S_DATA: begin
          r_shift <= {bit_in, r_shift[DATA_WIDTH-1:1]};
          r_par   <= r_par ^ bit_in;
          r_cnt   <= w_data_last ? 4'd0 : r_cnt + 4'd1;
        end
        S_PAR: begin
          r_perr <= bit_in ^ r_par ^ r_podd;
        end
        S_STOP: begin
          r_ferr <= w_ferr_fin;
          r_cnt  <= w_done ? 4'd0 : r_cnt + 4'd1;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Result registers: update only on completion, busy spans the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data <= '0;
      r_fv      <= 1'b0;
      r_perr_o  <= 1'b0;
      r_ferr_o  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_fv <= w_done;
      if (w_start) begin
        r_busy <= 1'b1;
      end
      if (w_done) begin
        r_rx_data <= r_shift;
        r_perr_o  <= r_perr;
        r_ferr_o  <= w_ferr_fin;
        r_busy    <= 1'b0;
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign frame_valid   = r_fv;
  assign parity_error  = r_perr_o;
  assign framing_error = r_ferr_o;
  assign busy          = r_busy;

`ifdef RX_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_bad;

  assign w_bad = w_done & (r_perr | w_ferr_fin);

  // Saturating bad-frame counter; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (w_bad && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_rx_frame_checker.sv
// Bench for rx_frame_checker: table vectors, corner sequences, random frames.
// Instance u1 uses one stop bit, u2 two stop bits with a 2-bit error counter.
module tb_rx_frame_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       bv1, bv2, bit_in, pen, podd, clr;
  logic [7:0] d1, d2;
  logic       fv1, pe1, fe1, b1;
  logic       fv2, pe2, fe2, b2;
`ifdef RX_ERR_COUNT_EN
  logic       clr1 = 1'b0;
  logic [7:0] ec1;
  logic [1:0] ec2;
  int         m_ec = 0;
`endif

  int checks = 0;
  int failures = 0;
  int n1 = 0, n2 = 0;
  int f1 = 0, f2 = 0;

  always #5 clk = ~clk;

  rx_frame_checker #(.DATA_WIDTH(8), .STOP_BITS(1), .ERR_CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .bit_valid(bv1), .bit_in(bit_in),
    .parity_en(pen), .parity_odd(podd),
`ifdef RX_ERR_COUNT_EN
    .err_clr(clr1), .err_count(ec1),
`endif
    .rx_data(d1), .frame_valid(fv1), .parity_error(pe1),
    .framing_error(fe1), .busy(b1)
  );

  rx_frame_checker #(.DATA_WIDTH(8), .STOP_BITS(2), .ERR_CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .bit_valid(bv2), .bit_in(bit_in),
    .parity_en(pen), .parity_odd(podd),
`ifdef RX_ERR_COUNT_EN
    .err_clr(clr), .err_count(ec2),
`endif
    .rx_data(d2), .frame_valid(fv2), .parity_error(pe2),
    .framing_error(fe2), .busy(b2)
  );

  always @(posedge clk) begin
    if (fv1) n1++;
    if (fv2) n2++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       stop;
    logic [7:0] e_data;
    logic       e_perr;
    logic       e_ferr;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic strobe(input int sel, input logic b, input logic c);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      bit_in = 1'($urandom);
      @(negedge clk);
    end
    bit_in = b;
    clr = c;
    if (sel == 1) bv1 = 1'b1;
    else bv2 = 1'b1;
    @(negedge clk);
    bv1 = 1'b0;
    bv2 = 1'b0;
    clr = 1'b0;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] data,
                            input logic pe, input logic po,
                            input logic pbit, input logic s1,
                            input logic s2, input logic c);
    pen = pe;
    podd = po;
    strobe(sel, 1'b0, 1'b0);
    chk("busy_start", (sel == 1) ? b1 : b2, 1);
    pen = 1'($urandom);
    podd = 1'($urandom);
    for (int i = 0; i < 8; i++) strobe(sel, data[i], 1'b0);
    if (pe) strobe(sel, pbit, 1'b0);
    chk("no_early_fv", (sel == 1) ? n1 : n2, (sel == 1) ? f1 : f2);
    if (sel == 1) begin
      strobe(sel, s1, c);
      f1++;
    end else begin
      strobe(sel, s1, 1'b0);
      chk("busy_mid", b2, 1);
      strobe(sel, s2, c);
      f2++;
    end
  endtask

  task automatic check_done(input int sel, input string nm,
                            input logic [7:0] ed, input logic ep,
                            input logic ef);
    chk({nm, "_fv"}, (sel == 1) ? fv1 : fv2, 1);
    chk({nm, "_data"}, (sel == 1) ? d1 : d2, ed);
    chk({nm, "_perr"}, (sel == 1) ? pe1 : pe2, ep);
    chk({nm, "_ferr"}, (sel == 1) ? fe1 : fe2, ef);
    chk({nm, "_busy"}, (sel == 1) ? b1 : b2, 0);
    @(negedge clk);
    chk({nm, "_fv_low"}, (sel == 1) ? fv1 : fv2, 0);
  endtask

  task automatic err_upd(input logic bad, input logic c);
`ifdef RX_ERR_COUNT_EN
    if (c) m_ec = 0;
    else if (bad && m_ec < 3) m_ec++;
    chk("err_count", ec2, m_ec);
`else
    pen = pen ^ bad ^ c ^ bad ^ c;
`endif
  endtask

  function automatic logic model_perr(input logic [7:0] data,
                                      input logic pe, input logic po,
                                      input logic pbit);
    int ones;
    ones = $countones(data) + int'(pbit);
    return pe && ((ones % 2) != int'(po));
  endfunction

  initial begin
    logic [7:0] rd;
    logic       rpe, rpo, rpb, rs1, rs2, rc, ep, ef;

    rst = 1'b1;
    bv1 = 1'b0;
    bv2 = 1'b0;
    bit_in = 1'b1;
    pen = 1'b0;
    podd = 1'b0;
    clr = 1'b0;

    tbl[0] = '{8'hA5, 1, 0, 0, 1, 8'hA5, 0, 0};
    tbl[1] = '{8'hA5, 1, 0, 1, 1, 8'hA5, 1, 0};
    tbl[2] = '{8'hA5, 1, 1, 1, 1, 8'hA5, 0, 0};
    tbl[3] = '{8'hFF, 1, 1, 0, 1, 8'hFF, 1, 0};
    tbl[4] = '{8'h00, 0, 0, 0, 0, 8'h00, 0, 1};
    tbl[5] = '{8'h3C, 0, 0, 0, 0, 8'h3C, 0, 1};

    repeat (3) @(negedge clk);
    chk("rst_data", d1, 0);
    chk("rst_fv", fv1, 0);
    chk("rst_perr", pe1, 0);
    chk("rst_ferr", fe1, 0);
    chk("rst_busy", b1, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send_frame(1, tbl[i].data, tbl[i].pen, tbl[i].podd,
                 tbl[i].pbit, tbl[i].stop, 1'b1, 1'b0);
      check_done(1, $sformatf("tbl%0d", i), tbl[i].e_data,
                 tbl[i].e_perr, tbl[i].e_ferr);
    end

    pen = 1'b1;
    podd = 1'b0;
    strobe(1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) strobe(1, 1'b1, 1'b0);
    chk("mid_hold_data", d1, 8'h3C);
    chk("mid_hold_ferr", fe1, 1);
    chk("mid_busy", b1, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", d1, 0);
    chk("arst_ferr", fe1, 0);
    chk("arst_perr", pe1, 0);
    chk("arst_fv", fv1, 0);
    chk("arst_busy", b1, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_done(1, "after_rst", 8'h5A, 0, 0);

    send_frame(2, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_done(2, "stop2", 8'h81, 0, 1);
    err_upd(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      strobe(2, 1'b1, 1'b0);
      chk("idle_busy", b2, 0);
    end
    chk("idle_fv_cnt", n2, f2);

    send_frame(2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_done(2, "break", 8'h00, 0, 1);
    err_upd(1'b1, 1'b0);
    send_frame(2, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_done(2, "perr2", 8'h01, 1, 0);
    err_upd(1'b1, 1'b0);
    send_frame(2, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_done(2, "stop2b", 8'hC3, 0, 1);
    err_upd(1'b1, 1'b0);
    send_frame(2, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_done(2, "clr_bad", 8'h7E, 1, 1);
    err_upd(1'b1, 1'b1);
    send_frame(2, 8'h96, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_done(2, "good2", 8'h96, 0, 0);
    err_upd(1'b0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      rd = 8'($urandom);
      rpe = 1'($urandom);
      rpo = 1'($urandom);
      rpb = 1'($urandom);
      rs1 = ($urandom_range(0, 3) != 0);
      send_frame(1, rd, rpe, rpo, rpb, rs1, 1'b1, 1'b0);
      check_done(1, "rnd1", rd, model_perr(rd, rpe, rpo, rpb), !rs1);
    end

    for (int k = 0; k < 20; k++) begin
      rd = 8'($urandom);
      rpe = 1'($urandom);
      rpo = 1'($urandom);
      rpb = 1'($urandom);
      rs1 = ($urandom_range(0, 3) != 0);
      rs2 = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 4) == 0);
      ep = model_perr(rd, rpe, rpo, rpb);
      ef = !(rs1 && rs2);
      send_frame(2, rd, rpe, rpo, rpb, rs1, rs2, rc);
      check_done(2, "rnd2", rd, ep, ef);
      err_upd(ep || ef, rc);
    end

    repeat (2) @(negedge clk);
    chk("fv_count1", n1, f1);
    chk("fv_count2", n2, f2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
